t09_frame_diff_tracker: RTL and testbench
=========================================

Name: t09_frame_diff_tracker

Overview:
- Parametrised successor to the snake-game frame tracker.
- Holds a GRID_W x GRID_H shadow frame of object codes and scans incoming cell codes in raster order.
- Emits one diff record (x, y, new code) per changed cell through a valid/ready handshake to the display-update logic, with backpressure to the pixel source.
- Adds a sequential frame-clear sweep and a per-frame diff count.

Parameters:
- GRID_W, 16, cells per row (>=2)
- GRID_H, 12, rows per frame (>=2)
- CODE_W, 3, object code width

Ports:
- clk  in  1  clock
- nrst  in  1  reset, asynchronous, active-low
- pix_valid  in  1  obj_in valid for current scan cell
- pix_ready  out  1  tracker accepts obj_in this cycle
- obj_in  in  CODE_W  object code of current cell
- sync  in  1  restart scan at (0,0)
- clear  in  1  request zeroing of shadow frame
- diff_valid  out  1  diff record pending
- diff_ready  in  1  consumer accepts diff record
- diff_x  out  $clog2(GRID_W)  column of changed cell
- diff_y  out  $clog2(GRID_H)  row of changed cell
- diff_code  out  CODE_W  new code of changed cell
- cur_x  out  $clog2(GRID_W)  current scan column
- cur_y  out  $clog2(GRID_H)  current scan row
- frame_done  out  1  one-cycle pulse after last cell accepted
- diff_count  out  $clog2(GRID_W*GRID_H+1)  diffs in last completed frame
- busy  out  1  clear sweep in progress

Behaviour:
- Reset:
  - All outputs 0.
  - State SCAN, cur=(0,0).
  - All shadow entries 0 (EMPTY).
- Storage index = y*GRID_W + x; raster order, x fastest.
- pix_ready = (state==SCAN) && !(diff_valid && !diff_ready) && !sync.
- Accept = pix_valid && pix_ready. On accept:
  - compare obj_in with shadow[cur];
  - if different, write shadow, load diff_x/y/code, set diff_valid next cycle (latency 1), increment running count;
  - advance cur.
- diff_valid holds its record stable until diff_valid && diff_ready; clears that cycle unless a new diff loads the same cycle (new record wins).
- Wrap: accept at (GRID_W-1, GRID_H-1):
  - cur becomes (0,0);
  - frame_done=1 for one cycle;
  - diff_count latches the running count including this cell;
  - running count resets to 0.
- sync (priority over pix_valid): cur=(0,0), running count=0, pending diff dropped (diff_valid=0), shadow untouched, no frame_done.
- clear in SCAN:
  - enters CLEAR; busy=1, pix_ready=0;
  - zeroes one entry per cycle from index 0 upward;
  - returns to SCAN after GRID_W*GRID_H cycles with cur=(0,0), running count=0, diff_valid=0.
  - clear while in CLEAR is ignored.
  - sync during CLEAR is ignored.
- States: SCAN, CLEAR. No other states.
- Counters saturate never; widths sized so no overflow.
- Reset asserted mid-scan or mid-clear restores reset values immediately.

Optional Feature:
- Macro T09_FORCE_REFRESH_EN.
- With it defined:
  - extra input force_refresh (1 bit), sampled at a frame start (cur=(0,0) after wrap, sync or clear);
  - when set, every accepted cell of that whole frame is reported as a diff regardless of equality; shadow still written.
- Without it: port absent; only true changes are reported.

Decomposition:
- Package t09_snake_pkg:
  - object code constants EMPTY=0, HEAD=1, BODY=2, APPLE=3, BORDER=4;
  - state enum {SCAN, CLEAR}.
- Sub-module t09_grid_scan_counter (parameters GRID_W, GRID_H):
  - inputs: advance, restart;
  - outputs: x, y, last_cell.
- Used for both scan position and clear index.

Test Plan:
- Reset, feed full frame of all EMPTY with diff_ready=1 -> no diff_valid; frame_done once after 192 accepts; diff_count=0.
- Feed APPLE at (5,3) only, diff_ready=1 -> one record x=5, y=3, code=3, one cycle after accept; diff_count=1; same frame repeated -> diff_count=0.
- Two consecutive changed cells with diff_ready=0 -> pix_ready drops after first diff; second cell held; raise diff_ready -> both records delivered in order, none lost.
- Assert sync at (7,2) with a pending diff -> diff_valid=0 next cycle; cur=(0,0); no frame_done.
- Assert clear -> busy=1 for exactly 192 cycles; pix_ready=0 throughout; re-feed the previous frame -> every non-EMPTY cell reported.
- With T09_FORCE_REFRESH_EN, force_refresh=1 at frame start, identical frame -> 192 diff records; diff_count=192.

Source files
------------

// File: rtl/t09_snake_pkg.sv
// Shared object codes and tracker state type for the snake frame tracker slice.
package t09_snake_pkg;

  localparam logic [2:0] EMPTY  = 3'd0;
  localparam logic [2:0] HEAD   = 3'd1;
  localparam logic [2:0] BODY   = 3'd2;
  localparam logic [2:0] APPLE  = 3'd3;
  localparam logic [2:0] BORDER = 3'd4;

  typedef enum logic {
    SCAN  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/t09_grid_scan_counter.sv
// Raster-order (x fastest) cell position counter over a GRID_W x GRID_H grid.
module t09_grid_scan_counter #(
  parameter int GRID_W = 16,
  parameter int GRID_H = 12
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      advance,
  input  logic                      restart,
  output logic [$clog2(GRID_W)-1:0] x,
  output logic [$clog2(GRID_H)-1:0] y,
  output logic                      last_cell
);

  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);

  logic x_last;
  logic y_last;

  assign x_last    = (x == XW'(GRID_W - 1));
  assign y_last    = (y == YW'(GRID_H - 1));
  assign last_cell = x_last && y_last;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      x <= '0;
      y <= '0;
    end else if (restart) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (x_last) begin
        x <= '0;
        y <= y_last ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/t09_frame_diff_tracker.sv
// Shadow-frame diff tracker: emits (x, y, code) for each changed cell in raster order.
// Optional force_refresh input enabled by defining T09_FORCE_REFRESH_EN.
module t09_frame_diff_tracker
  import t09_snake_pkg::*;
#(
  parameter int GRID_W = 16,
  parameter int GRID_H = 12,
  parameter int CODE_W = 3
) (
  input  logic                                  clk,
  input  logic                                  nrst,
  input  logic                                  pix_valid,
  output logic                                  pix_ready,
  input  logic [CODE_W-1:0]                     obj_in,
  input  logic                                  sync,
  input  logic                                  clear,
`ifdef T09_FORCE_REFRESH_EN
  input  logic                                  force_refresh,
`endif
  output logic                                  diff_valid,
  input  logic                                  diff_ready,
  output logic [$clog2(GRID_W)-1:0]             diff_x,
  output logic [$clog2(GRID_H)-1:0]             diff_y,
  output logic [CODE_W-1:0]                     diff_code,
  output logic [$clog2(GRID_W)-1:0]             cur_x,
  output logic [$clog2(GRID_H)-1:0]             cur_y,
  output logic                                  frame_done,
  output logic [$clog2(GRID_W*GRID_H+1)-1:0]    diff_count,
  output logic                                  busy
);

  localparam int unsigned CELLS = GRID_W * GRID_H;
  localparam int          XW    = $clog2(GRID_W);
  localparam int          YW    = $clog2(GRID_H);
  localparam int          IDX_W = $clog2(CELLS);
  localparam int          CNT_W = $clog2(CELLS + 1);

  state_t            state;
  logic [CODE_W-1:0] shadow [CELLS];
  logic [XW-1:0]     clr_x;
  logic [YW-1:0]     clr_y;
  logic              scan_last;
  logic              clr_last;
  logic [IDX_W-1:0]  scan_idx;
  logic [IDX_W-1:0]  clr_idx;
  logic              in_scan;
  logic              accept;
  logic              load_diff;
  logic              wrap;
  logic              force_eff;
  logic [CNT_W-1:0]  run_count;

  assign in_scan   = (state == SCAN);
  assign busy      = (state == CLEAR);
  // nrst term keeps pix_ready low while reset is held
  assign pix_ready = nrst && in_scan && !(diff_valid && !diff_ready) && !sync;
  assign accept    = pix_valid && pix_ready;
  assign scan_idx  = IDX_W'(cur_y) * IDX_W'(GRID_W) + IDX_W'(cur_x);
  assign clr_idx   = IDX_W'(clr_y) * IDX_W'(GRID_W) + IDX_W'(clr_x);
  assign load_diff = accept && ((obj_in != shadow[scan_idx]) || force_eff);
  assign wrap      = accept && scan_last;

`ifdef T09_FORCE_REFRESH_EN
  logic force_frame;
  logic at_origin;

  // The first cell of a frame uses the live input; later cells use the latched copy.
  assign at_origin = (cur_x == '0) && (cur_y == '0);
  assign force_eff = at_origin ? force_refresh : force_frame;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      force_frame <= 1'b0;
    end else if (in_scan && at_origin) begin
      force_frame <= force_refresh;
    end
  end
`else
  assign force_eff = 1'b0;
`endif

  t09_grid_scan_counter #(
    .GRID_W(GRID_W),
    .GRID_H(GRID_H)
  ) u_scan (
    .clk       (clk),
    .nrst      (nrst),
    .advance   (accept),
    .restart   (!in_scan || clear || sync),
    .x         (cur_x),
    .y         (cur_y),
    .last_cell (scan_last)
  );

  t09_grid_scan_counter #(
    .GRID_W(GRID_W),
    .GRID_H(GRID_H)
  ) u_clr (
    .clk       (clk),
    .nrst      (nrst),
    .advance   (!in_scan),
    .restart   (in_scan),
    .x         (clr_x),
    .y         (clr_y),
    .last_cell (clr_last)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int unsigned i = 0; i < CELLS; i++) begin
        shadow[IDX_W'(i)] <= CODE_W'(EMPTY);
      end
    end else if (!in_scan) begin
      shadow[clr_idx] <= CODE_W'(EMPTY);
    end else if (accept) begin
      shadow[scan_idx] <= obj_in;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= SCAN;
      diff_valid <= 1'b0;
      diff_x     <= '0;
      diff_y     <= '0;
      diff_code  <= '0;
      run_count  <= '0;
      diff_count <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        SCAN: begin
          if (clear) begin
            state      <= CLEAR;
            diff_valid <= 1'b0;
            run_count  <= '0;
          end else if (sync) begin
            diff_valid <= 1'b0;
            run_count  <= '0;
          end else begin
            if (load_diff) begin
              diff_valid <= 1'b1;
              diff_x     <= cur_x;
              diff_y     <= cur_y;
              diff_code  <= obj_in;
            end else if (diff_ready) begin
              diff_valid <= 1'b0;
            end
            if (wrap) begin
              frame_done <= 1'b1;
              diff_count <= run_count + CNT_W'(load_diff);
              run_count  <= '0;
            end else if (load_diff) begin
              run_count <= run_count + 1'b1;
            end
          end
        end
        CLEAR: begin
          diff_valid <= 1'b0;
          run_count  <= '0;
          if (clr_last) begin
            state <= SCAN;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_t09_frame_diff_tracker.sv
// Bench for t09_frame_diff_tracker: table-driven frames, handshake corner cases, random frames vs a cell-level model.
module tb_t09_frame_diff_tracker;
  import t09_snake_pkg::*;

  localparam int GW = 16;
  localparam int GH = 12;
  localparam int CW = 3;
  localparam int N  = GW * GH;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          pix_valid = 1'b0;
  logic          sync = 1'b0;
  logic          clear = 1'b0;
  logic          diff_ready = 1'b0;
  logic          force_refresh = 1'b0;
  logic [CW-1:0] obj_in = '0;
  logic          pix_ready, diff_valid, frame_done, busy;
  logic [3:0]    diff_x, cur_x, diff_y, cur_y;
  logic [CW-1:0] diff_code;
  logic [7:0]    diff_count;

  t09_frame_diff_tracker #(
    .GRID_W(GW),
    .GRID_H(GH),
    .CODE_W(CW)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .obj_in     (obj_in),
    .sync       (sync),
    .clear      (clear),
`ifdef T09_FORCE_REFRESH_EN
    .force_refresh (force_refresh),
`endif
    .diff_valid (diff_valid),
    .diff_ready (diff_ready),
    .diff_x     (diff_x),
    .diff_y     (diff_y),
    .diff_code  (diff_code),
    .cur_x      (cur_x),
    .cur_y      (cur_y),
    .frame_done (frame_done),
    .diff_count (diff_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Cell-level model: linear cursor position, shadow image, pending record
  int m_shadow [N];
  int m_pos, m_run, m_count, m_busy;
  int m_rx, m_ry, m_rc;
  bit m_pending, m_fd, m_force, m_last_acc;
  bit exp_ready, acc, chg, feff;
  int n_delivered = 0;
  int n_fd = 0;

  task automatic m_reset();
    foreach (m_shadow[i]) m_shadow[i] = 0;
    m_pos = 0; m_run = 0; m_count = 0; m_busy = 0;
    m_pending = 0; m_fd = 0; m_force = 0;
  endtask

  // Sample 1 ns before each rising edge; inputs change on falling edges
  always begin
    @(negedge clk);
    #4;
    if (!nrst) begin
      chk("rst_pix_ready",  int'(pix_ready), 0);
      chk("rst_diff_valid", int'(diff_valid), 0);
      chk("rst_frame_done", int'(frame_done), 0);
      chk("rst_busy",       int'(busy), 0);
      chk("rst_diff_count", int'(diff_count), 0);
      chk("rst_cur_x",      int'(cur_x), 0);
      chk("rst_cur_y",      int'(cur_y), 0);
      chk("rst_diff_rec",   int'(diff_x) + int'(diff_y) + int'(diff_code), 0);
      m_reset();
      m_last_acc = 0;
    end else begin
      exp_ready = (m_busy == 0) && !(m_pending && !diff_ready) && !sync;
      chk("pix_ready",  int'(pix_ready), int'(exp_ready));
      chk("diff_valid", int'(diff_valid), int'(m_pending));
      if (m_pending) begin
        chk("diff_x",    int'(diff_x), m_rx);
        chk("diff_y",    int'(diff_y), m_ry);
        chk("diff_code", int'(diff_code), m_rc);
      end
      chk("busy",       int'(busy), int'(m_busy > 0));
      chk("frame_done", int'(frame_done), int'(m_fd));
      chk("diff_count", int'(diff_count), m_count);
      chk("cur_x",      int'(cur_x), m_pos % GW);
      chk("cur_y",      int'(cur_y), m_pos / GW);
      if (diff_valid && diff_ready) n_delivered++;
      if (frame_done) n_fd++;
      m_last_acc = 0;
      m_fd = 0;
      if (m_busy > 0) begin
        m_busy--;
      end else begin
        feff = (m_pos == 0) ? force_refresh : m_force;
        if (m_pos == 0) m_force = force_refresh;
        if (clear) begin
          m_busy = N; m_pending = 0; m_run = 0; m_pos = 0;
          foreach (m_shadow[i]) m_shadow[i] = 0;
        end else if (sync) begin
          m_pos = 0; m_run = 0; m_pending = 0;
        end else begin
          acc = pix_valid && exp_ready;
          m_last_acc = acc;
          if (m_pending && diff_ready) m_pending = 0;
          if (acc) begin
            chg = (int'(obj_in) != m_shadow[m_pos]) || feff;
            m_shadow[m_pos] = int'(obj_in);
            if (chg) begin
              m_pending = 1; m_rx = m_pos % GW; m_ry = m_pos / GW; m_rc = int'(obj_in);
              m_run++;
            end
            if (m_pos == N - 1) begin
              m_fd = 1; m_count = m_run; m_run = 0; m_pos = 0;
            end else begin
              m_pos++;
            end
          end
        end
      end
    end
  end

  int img   [N];
  int saved [N];
  bit rand_ready = 0;

  task automatic send(input int code);
    int tries;
    tries = 0;
    pix_valid = 1'b1;
    obj_in = CW'(code);
    do begin
      if (rand_ready) diff_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      tries++;
    end while (!m_last_acc && tries < 200);
    if (!m_last_acc) chk("send_timeout", 0, 1);
  endtask

  task automatic feed_img();
    for (int i = 0; i < N; i++) send(img[i]);
    pix_valid = 1'b0;
  endtask

  task automatic drain();
    pix_valid = 1'b0;
    diff_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic copy_shadow();
    foreach (img[i]) img[i] = m_shadow[i];
  endtask

  typedef struct {
    int x;
    int y;
    int code;
    int exp_diffs;
  } vec_t;

  vec_t vecs [7];
  int d0, f0, nz, cnt, syncs, i;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{0, 0, 0, 0};
    vecs[1] = '{5, 3, 3, 1};
    vecs[2] = '{5, 3, 3, 0};
    vecs[3] = '{5, 3, 0, 1};
    vecs[4] = '{15, 11, 4, 1};
    vecs[5] = '{0, 0, 1, 2};
    vecs[6] = '{0, 0, 1, 0};

    repeat (3) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    // Single-object frames against a known shadow history
    for (int v = 0; v < 7; v++) begin
      d0 = n_delivered; f0 = n_fd;
      foreach (img[k]) img[k] = 0;
      img[vecs[v].y * GW + vecs[v].x] = vecs[v].code;
      diff_ready = 1'b1;
      feed_img();
      drain();
      chk("vec_diff_records", n_delivered - d0, vecs[v].exp_diffs);
      chk("vec_frame_done",   n_fd - f0, 1);
      chk("vec_diff_count",   int'(diff_count), vecs[v].exp_diffs);
    end

    // Backpressure: two adjacent changed cells with the consumer stalled
    copy_shadow();
    img[10] = (img[10] + 1) % 5;
    img[11] = (img[11] + 1) % 5;
    d0 = n_delivered;
    diff_ready = 1'b0;
    for (int k = 0; k <= 10; k++) send(img[k]);
    pix_valid = 1'b1;
    obj_in = CW'(img[11]);
    repeat (4) begin
      @(negedge clk);
      #1;
      chk("bp_ready_low", int'(pix_ready), 0);
      chk("bp_hold_x",    int'(cur_x), 11);
      chk("bp_rec_x",     int'(diff_x), 10);
    end
    diff_ready = 1'b1;
    for (int k = 11; k < N; k++) send(img[k]);
    drain();
    chk("bp_records", n_delivered - d0, 2);

    // sync at (7,2) with an undelivered record
    copy_shadow();
    img[38] = (img[38] + 1) % 5;
    diff_ready = 1'b0;
    for (int k = 0; k <= 38; k++) send(img[k]);
    pix_valid = 1'b0;
    chk("sync_pending", int'(diff_valid), 1);
    chk("sync_at_x", int'(cur_x), 7);
    chk("sync_at_y", int'(cur_y), 2);
    f0 = n_fd;
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    #1;
    chk("sync_drop_valid", int'(diff_valid), 0);
    chk("sync_cur_x", int'(cur_x), 0);
    chk("sync_cur_y", int'(cur_y), 0);
    diff_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("sync_no_frame_done", n_fd - f0, 0);
    copy_shadow();
    feed_img();
    drain();

    // Random frame, then clear sweep (with ignored clear/sync mid-sweep), then re-feed
    foreach (img[k]) img[k] = $urandom_range(0, 4);
    img[0] = APPLE;
    feed_img();
    drain();
    nz = 0;
    foreach (img[k]) begin
      saved[k] = img[k];
      if (img[k] != 0) nz++;
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    cnt = 0;
    while (busy && cnt < 300) begin
      chk("clear_pix_ready", int'(pix_ready), 0);
      cnt++;
      clear = (cnt == 50);
      sync  = (cnt == 50);
      @(negedge clk);
    end
    clear = 1'b0;
    sync = 1'b0;
    chk("clear_busy_cycles", cnt, N);
    d0 = n_delivered;
    foreach (img[k]) img[k] = saved[k];
    feed_img();
    drain();
    chk("clear_refeed_records", n_delivered - d0, nz);
    chk("clear_refeed_count", int'(diff_count), nz);

    // Random frames with random consumer stalls and an occasional sync
    rand_ready = 1;
    for (int f = 0; f < 4; f++) begin
      copy_shadow();
      foreach (img[k]) if ($urandom_range(0, 2) == 0) img[k] = $urandom_range(0, 4);
      syncs = 0;
      i = 0;
      while (i < N) begin
        if (syncs == 0 && $urandom_range(0, 150) == 0) begin
          pix_valid = 1'b0;
          sync = 1'b1;
          @(negedge clk);
          sync = 1'b0;
          syncs++;
          i = 0;
        end else begin
          send(img[i]);
          i++;
        end
      end
      rand_ready = (f < 3);
      drain();
    end
    rand_ready = 0;

`ifdef T09_FORCE_REFRESH_EN
    // Forced refresh of an unchanged frame reports every cell
    copy_shadow();
    d0 = n_delivered;
    diff_ready = 1'b1;
    force_refresh = 1'b1;
    send(img[0]);
    force_refresh = 1'b0;
    for (int k = 1; k < N; k++) send(img[k]);
    drain();
    chk("force_records", n_delivered - d0, N);
    chk("force_count", int'(diff_count), N);
    d0 = n_delivered;
    feed_img();
    drain();
    chk("force_after_records", n_delivered - d0, 0);
`endif

    // Reset mid-scan clears the shadow frame
    foreach (img[k]) img[k] = 0;
    img[100] = BODY;
    feed_img();
    drain();
    for (int k = 0; k < 20; k++) send(img[k]);
    pix_valid = 1'b0;
    nrst = 1'b0;
    #1;
    chk("midrst_cur_x", int'(cur_x), 0);
    chk("midrst_busy", int'(busy), 0);
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    d0 = n_delivered;
    foreach (img[k]) img[k] = 0;
    feed_img();
    drain();
    chk("midrst_empty_records", n_delivered - d0, 0);
    chk("midrst_empty_count", int'(diff_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
